filtro_mac_datapath: RTL

//  Datapath end of the sequencer/MAC interface. Consumes per-cycle sel_const/sel_fun/sel_acum

---
 rtl/filtro_mac_pkg.sv | 49 ++++
 rtl/mult_fix.sv | 46 ++++
 rtl/filtro_mac_datapath.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/filtro_mac_pkg.sv
// Shared definitions for the filtro_mac datapath.
//  - WIDTH / FRAC : operand and accumulator format, Q(WIDTH-FRAC-1).FRAC signed
//  - NUM_CONST    : depth of the constant table
//  - FUN_ZERO     : sel_fun code that selects a zero operand
//  - fit()        : brings a 2*WIDTH signed value back to WIDTH bits
// Build option: SAT_EN defined -> fit() saturates and reports clipping;
//               SAT_EN undefined -> fit() wraps modulo 2^WIDTH and never reports clipping.
package filtro_mac_pkg;

    localparam int WIDTH     = 16;
    localparam int FRAC      = 8;
    localparam int NUM_CONST = 8;

    localparam logic [1:0] FUN_ZERO = 2'b11;

`ifdef SAT_EN
    localparam logic SAT_ON = 1'b1;
`else
    localparam logic SAT_ON = 1'b0;
`endif

    // Largest and smallest WIDTH-bit values, held in the wide 2*WIDTH domain
    localparam logic signed [2*WIDTH-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             clip;
    } fit_t;

    // Narrow a wide signed value to WIDTH bits: saturate when enabled, otherwise wrap
    function automatic fit_t fit(input logic signed [2*WIDTH-1:0] v);
        fit_t r;
        r.val  = v[WIDTH-1:0];
        r.clip = 1'b0;
        if (SAT_ON && (v > SAT_MAX)) begin
            r.val  = SAT_MAX[WIDTH-1:0];
            r.clip = 1'b1;
        end else if (SAT_ON && (v < SAT_MIN)) begin
            r.val  = SAT_MIN[WIDTH-1:0];
            r.clip = 1'b1;
        end else begin
            r.val  = v[WIDTH-1:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_fix.sv
// Stage-1 fixed-point multiplier: registers fit((k_i * f_i) >>> FRAC).
// The full 2*WIDTH product is formed first so the multiply itself never overflows;
// the arithmetic shift truncates toward -inf before narrowing.
// Ports:
//  clk, reset : clock, synchronous active-high reset
//  k_i, f_i   : signed WIDTH-bit operands
//  p_q        : registered narrowed product
//  ovf_q      : registered "product was clipped" flag (only ever set with SAT_EN)
module mult_fix
    import filtro_mac_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] k_i,
    input  logic [WIDTH-1:0] f_i,
    output logic [WIDTH-1:0] p_q,
    output logic             ovf_q
);

    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [2*WIDTH-1:0] shift_s;
    fit_t                      fit_s;
    logic [WIDTH-1:0]          p_d;
    logic                      ovf_d;

    // Wide signed product, scale back by FRAC, narrow to WIDTH
    always_comb begin
        prod_s  = $signed({{WIDTH{k_i[WIDTH-1]}}, k_i}) * $signed({{WIDTH{f_i[WIDTH-1]}}, f_i});
        shift_s = prod_s >>> FRAC;
        fit_s   = fit(shift_s);
        p_d     = fit_s.val;
        ovf_d   = fit_s.clip;
    end

    // Product pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q   <= {WIDTH{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/filtro_mac_datapath.sv
// Datapath side of the sequencer/MAC interface. Each cycle the sequencer issues a
// (sel_const, sel_fun, sel_acum) step; the product K[sel_const]*F[sel_fun] is formed in
// stage 1 and added to the accumulator in stage 2. A rising Band_Listo publishes the
// accumulator on resultado with a one-cycle resultado_valido pulse, two cycles later.
// Build option: SAT_EN (see filtro_mac_pkg) selects saturating arithmetic and the
// sticky overflow flag; without it arithmetic wraps and overflow stays 0.
// Ports:
//  clk, reset              : clock, synchronous active-high reset
//  Bandera                 : sequence start, clears accumulator and overflow
//  sel_const/sel_fun       : operand selects (sel_fun=3 selects zero)
//  sel_acum                : accumulate this step's product
//  Band_Listo              : sequence done level
//  const_we/addr/data      : constant table write port
//  fun_0, fun_1, fun_2     : function samples
//  resultado               : last completed sum
//  resultado_valido        : one-cycle pulse when resultado updates
//  overflow                : sticky clip flag
module filtro_mac_datapath
    import filtro_mac_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             Bandera,
    input  logic [2:0]       sel_const,
    input  logic [1:0]       sel_fun,
    input  logic             sel_acum,
    input  logic             Band_Listo,
    input  logic             const_we,
    input  logic [2:0]       const_addr,
    input  logic [WIDTH-1:0] const_data,
    input  logic [WIDTH-1:0] fun_0,
    input  logic [WIDTH-1:0] fun_1,
    input  logic [WIDTH-1:0] fun_2,
    output logic [WIDTH-1:0] resultado,
    output logic             resultado_valido,
    output logic             overflow
);

    logic [WIDTH-1:0] k_q [NUM_CONST];
    logic [WIDTH-1:0] k_d [NUM_CONST];
    logic [WIDTH-1:0] k_sel_s;
    logic [WIDTH-1:0] f_sel_s;

    logic [WIDTH-1:0] p1_q;
    logic             mult_ovf_q;
    logic             a1_q, a1_d;
    logic             l1_q, l1_d;

    logic [WIDTH-1:0]          acc_q, acc_d;
    logic                      ovf_q, ovf_d;
    logic signed [2*WIDTH-1:0] sum_s;
    fit_t                      add_fit_s;

    logic             listo_prev_q, listo_prev_d;
    logic             rise_s;
    logic [WIDTH-1:0] resultado_q, resultado_d;
    logic             valido_q, valido_d;

    // Constant table write; reads below see the pre-edge contents
    always_comb begin
        k_d = k_q;
        if (const_we) begin
            k_d[const_addr] = const_data;
        end else begin
            k_d = k_q;
        end
    end

    // Operand selection for stage 1
    always_comb begin
        k_sel_s = k_q[sel_const];
        case (sel_fun)
            2'b00:    f_sel_s = fun_0;
            2'b01:    f_sel_s = fun_1;
            2'b10:    f_sel_s = fun_2;
            FUN_ZERO: f_sel_s = {WIDTH{1'b0}};
            default:  f_sel_s = {WIDTH{1'b0}};
        endcase
    end

    mult_fix u_mult_fix (
        .clk   (clk),
        .reset (reset),
        .k_i   (k_sel_s),
        .f_i   (f_sel_s),
        .p_q   (p1_q),
        .ovf_q (mult_ovf_q)
    );

    // Stage 2: accumulate; Bandera discards the in-flight product and restarts
    always_comb begin
        a1_d      = sel_acum;
        l1_d      = Band_Listo;
        sum_s     = $signed({{WIDTH{acc_q[WIDTH-1]}}, acc_q}) + $signed({{WIDTH{p1_q[WIDTH-1]}}, p1_q});
        add_fit_s = fit(sum_s);
        if (Bandera) begin
            acc_d = {WIDTH{1'b0}};
            ovf_d = 1'b0;
        end else if (a1_q) begin
            acc_d = add_fit_s.val;
            ovf_d = ovf_q | add_fit_s.clip | mult_ovf_q;
        end else begin
            acc_d = acc_q;
            ovf_d = ovf_q | mult_ovf_q;
        end
    end

    // Completion: publish on the delayed rising edge of Band_Listo
    always_comb begin
        rise_s       = l1_q & ~listo_prev_q;
        listo_prev_d = l1_q;
        valido_d     = rise_s;
        if (rise_s) begin
            resultado_d = acc_q;
        end else begin
            resultado_d = resultado_q;
        end
    end

    // State registers for constant table, stage 1 controls, stage 2 and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CONST; i++) begin
                k_q[i] <= {WIDTH{1'b0}};
            end
            a1_q         <= 1'b0;
            // l1 and listo_prev both start high so a Band_Listo already
            // asserted when reset releases is not seen as a new rise.
            l1_q         <= 1'b1;
            listo_prev_q <= 1'b1;
            acc_q        <= {WIDTH{1'b0}};
            ovf_q        <= 1'b0;
            resultado_q  <= {WIDTH{1'b0}};
            valido_q     <= 1'b0;
        end else begin
            k_q          <= k_d;
            a1_q         <= a1_d;
            l1_q         <= l1_d;
            listo_prev_q <= listo_prev_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            resultado_q  <= resultado_d;
            valido_q     <= valido_d;
        end
    end

    assign resultado        = resultado_q;
    assign resultado_valido = valido_q;
    assign overflow         = ovf_q;

endmodule
